mpeg_input_stream_bitreader: RTL and testbench

Bit-granular reader placed directly downstream of the 8 KB MPEG input stream FIFO RAM (8-bit write port, 2048×32 read port, one-cycle registered read). It owns the RAM read port, tracks the read word pointer against the writer's byte pointer, and prefetches 32-bit words into a 64-bit MSB-aligned bit buffer. The MPEG parsers consume 1–32 bits per transfer through a valid/ready interface, with byte-align and flush commands.

---
 rtl/mpeg_input_stream_bitreader.sv | 101 ++++++++++
 tb/tb_mpeg_input_stream_bitreader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpeg_input_stream_bitreader.sv
// Bit-granular reader for the MPEG input stream FIFO: prefetches 32-bit words from
// the RAM read port into a 64-bit MSB-aligned buffer and serves 1..32-bit reads.
module mpeg_input_stream_bitreader (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] wr_ptr,
    output logic [10:0] raddr,
    input  logic [31:0] q,
    output logic [10:0] rd_word_ptr,
    input  logic        bits_valid,
    input  logic [5:0]  bits_len,
    output logic        bits_ready,
    output logic [31:0] bits_data,
    input  logic        align,
    input  logic        flush,
    output logic [6:0]  bit_count
);

    logic [63:0] buf_reg;
    logic [63:0] buf_next;
    logic [63:0] buf_ins;
    logic [6:0]  count_reg;
    logic [6:0]  count_next;
    logic [6:0]  count_ins;
    logic [10:0] rd_ptr_reg;
    logic [10:0] rd_ptr_next;
    logic        inflight_reg;
    logic        inflight_next;

    logic        avail;
    logic        issue;
    logic        fire;
    logic [63:0] q_shifted;
    logic [63:0] data_wide;

    assign avail      = (rd_ptr_reg != wr_ptr[12:2]);
    assign issue      = !inflight_reg && avail && (count_reg <= 7'd32) && !flush;
    assign bits_ready = (count_reg >= {1'b0, bits_len}) && !align && !flush;
    assign fire       = bits_valid && bits_ready;

    // Bits below count are always zero, so the returning word can simply be OR-ed in.
    assign q_shifted  = {q, 32'd0} >> count_reg;

    // A shift by 64 (bits_len == 0) yields zero, which is the required no-op data.
    assign data_wide  = buf_reg >> (7'd64 - {1'b0, bits_len});
    assign bits_data  = data_wide[31:0];

    assign raddr       = rd_ptr_reg;
    assign rd_word_ptr = rd_ptr_reg;
    assign bit_count   = count_reg;

    always_comb begin
        buf_ins       = buf_reg;
        count_ins     = count_reg;
        buf_next      = buf_reg;
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        inflight_next = issue;

        if (inflight_reg) begin
            buf_ins   = buf_reg | q_shifted;
            count_ins = count_reg + 7'd32;
        end

        if (flush) begin
            buf_next      = 64'd0;
            count_next    = 7'd0;
            rd_ptr_next   = wr_ptr[12:2];
            inflight_next = 1'b0;
        end else begin
            buf_next   = buf_ins;
            count_next = count_ins;
            // Alignment uses the pre-return count: returned words never change count % 8.
            if (align) begin
                buf_next   = buf_ins << count_reg[2:0];
                count_next = count_ins - {4'd0, count_reg[2:0]};
            end else if (fire) begin
                buf_next   = buf_ins << bits_len;
                count_next = count_ins - {1'b0, bits_len};
            end
            if (issue) begin
                rd_ptr_next = rd_ptr_reg + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_reg      <= 64'd0;
            count_reg    <= 7'd0;
            rd_ptr_reg   <= 11'd0;
            inflight_reg <= 1'b0;
        end else begin
            buf_reg      <= buf_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            inflight_reg <= inflight_next;
        end
    end

endmodule

// File: tb/tb_mpeg_input_stream_bitreader.sv
// Bench for mpeg_input_stream_bitreader: directed cycle-accurate scenarios followed by
// a randomized stream through pointer wrap, checked against a bit-position stream model.
module tb_mpeg_input_stream_bitreader;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] wr_ptr;
    logic [10:0] raddr;
    logic [31:0] q;
    logic [10:0] rd_word_ptr;
    logic        bits_valid;
    logic [5:0]  bits_len;
    logic        bits_ready;
    logic [31:0] bits_data;
    logic        align;
    logic        flush;
    logic [6:0]  bit_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:8191];
    localparam int TOTAL_BYTES = 9216;
    localparam int END_BITS    = 72000;
    logic [7:0] sbytes [0:TOTAL_BYTES-1];

    mpeg_input_stream_bitreader dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ptr      (wr_ptr),
        .raddr       (raddr),
        .q           (q),
        .rd_word_ptr (rd_word_ptr),
        .bits_valid  (bits_valid),
        .bits_len    (bits_len),
        .bits_ready  (bits_ready),
        .bits_data   (bits_data),
        .align       (align),
        .flush       (flush),
        .bit_count   (bit_count)
    );

    always #5 clk = ~clk;

    // 2048x32 RAM read port, first stream byte in the most significant lane.
    always @(posedge clk)
        q <= {mem[{raddr, 2'b00}], mem[{raddr, 2'b01}], mem[{raddr, 2'b10}], mem[{raddr, 2'b11}]};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push4(input logic [31:0] w);
        mem[wr_ptr]         = w[31:24];
        mem[wr_ptr + 13'd1] = w[23:16];
        mem[wr_ptr + 13'd2] = w[15:8];
        mem[wr_ptr + 13'd3] = w[7:0];
        wr_ptr = wr_ptr + 13'd4;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
    endtask

    task automatic show(input string what);
        $display("[TB] %s len=%0d data=0x%08h ready=%0d count=%0d rd=0x%03h",
                 what, bits_len, bits_data, bits_ready, bit_count, rd_word_ptr);
    endtask

    // Next n bits of the byte stream starting at bit position p, right-aligned.
    function automatic logic [31:0] model_bits(input int p, input int n);
        logic [31:0] r;
        logic [7:0]  b;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            b = sbytes[(p + i) >> 3];
            r = {r[30:0], b[7 - ((p + i) & 7)]};
        end
        return r;
    endfunction

    initial begin
        int written;
        int pos;
        int issued;
        int cyc;
        int d;
        int n;
        int len;
        bit do_align;
        bit wrapped;
        logic [10:0] prev_rd;

        reset = 1'b1; wr_ptr = 13'd0; bits_valid = 1'b0; bits_len = 6'd0;
        align = 1'b0; flush = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        for (int i = 0; i < TOTAL_BYTES; i++) sbytes[i] = 8'($urandom);

        // Reset state
        repeat (3) step();
        check("rst_count", bit_count, 0);
        check("rst_rdptr", rd_word_ptr, 0);
        check("rst_raddr", raddr, 0);
        check("rst_data", bits_data, 0);
        check("rst_ready_len0", bits_ready, 1);
        bits_len = 6'd8; settle();
        check("rst_ready_len8", bits_ready, 0);
        bits_len = 6'd0;
        reset = 1'b0;
        step();

        // First word: issue timing and first byte
        push4(32'h12345678); settle();
        check("t1_raddr", raddr, 0);
        step();
        check("t1_rd_after_issue", rd_word_ptr, 1);
        check("t1_count_mid", bit_count, 0);
        step();
        check("t1_count", bit_count, 32);
        bits_len = 6'd8; settle();
        check("t1_data8", bits_data, 8'h12);
        check("t1_ready8", bits_ready, 1);
        show("t1 peek");
        bits_len = 6'd0;
        do_flush();
        check("t1_flush_rd", rd_word_ptr, 1);

        // Two words, consume 4/12/32
        push4(32'hDEADBEEF); push4(32'h01234567);
        repeat (4) step();
        check("t2_count64", bit_count, 64);
        bits_valid = 1'b1; bits_len = 6'd4; settle();
        check("t2_d4", bits_data, 4'hD); check("t2_r4", bits_ready, 1); show("t2 xfer");
        step(); bits_len = 6'd12; settle();
        check("t2_d12", bits_data, 12'hEAD); show("t2 xfer");
        step(); bits_len = 6'd32; settle();
        check("t2_d32", bits_data, 32'hBEEF0123); show("t2 xfer");
        step(); bits_valid = 1'b0; bits_len = 6'd0; settle();
        check("t2_count16", bit_count, 16);
        do_flush();

        // Consume 3, then align
        push4(32'hA53C0FF0);
        step(); step();
        check("t3_count32", bit_count, 32);
        bits_valid = 1'b1; bits_len = 6'd3; settle();
        check("t3_d3", bits_data, 3'b101); show("t3 xfer");
        step(); bits_valid = 1'b0; settle();
        check("t3_count29", bit_count, 29);
        align = 1'b1; bits_len = 6'd8; settle();
        check("t3_ready_align", bits_ready, 0);
        step(); align = 1'b0; settle();
        check("t3_count24", bit_count, 24);
        check("t3_d8", bits_data, 8'h3C); check("t3_r8", bits_ready, 1); show("t3 peek");
        bits_len = 6'd0;
        do_flush();

        // Return and consume in the same cycle
        push4(32'h11223344);
        step(); step();
        check("t4_count32", bit_count, 32);
        bits_valid = 1'b1; bits_len = 6'd24; push4(32'hAABBCCDD); settle();
        check("t4_d24", bits_data, 24'h112233); show("t4 xfer");
        step(); bits_len = 6'd8; settle();
        check("t4_count8", bit_count, 8);
        check("t4_d8", bits_data, 8'h44); show("t4 xfer");
        step(); bits_valid = 1'b0; bits_len = 6'd32; settle();
        check("t4_count_net", bit_count, 32);
        check("t4_d32", bits_data, 32'hAABBCCDD); show("t4 peek");
        bits_len = 6'd0;
        do_flush();

        // Flush with a fetch in flight
        push4(32'hBADBAD00); settle();
        check("t5_raddr_stale", raddr, 6);
        step();
        flush = 1'b1; wr_ptr = 13'h1000;
        step(); flush = 1'b0; settle();
        check("t5_count0", bit_count, 0);
        check("t5_rd400", rd_word_ptr, 11'h400);
        check("t5_raddr400", raddr, 11'h400);
        step();
        bits_len = 6'd32; settle();
        check("t5_stale_count", bit_count, 0);
        check("t5_stale_data", bits_data, 0);
        push4(32'hCAFEF00D); settle();
        check("t5_raddr_next", raddr, 11'h400);
        step();
        check("t5_rd401", rd_word_ptr, 11'h401);
        step();
        check("t5_count32", bit_count, 32);
        check("t5_d32", bits_data, 32'hCAFEF00D); show("t5 peek");
        bits_len = 6'd0;
        do_flush();

        // Randomized stream through pointer wrap: 7-bit reads, then random lengths
        written = 0; pos = 0; issued = 0; cyc = 0; wrapped = 1'b0;
        prev_rd = rd_word_ptr;
        while (pos < END_BITS && cyc < 60000) begin
            if (rd_word_ptr != prev_rd) begin
                issued++;
                if (rd_word_ptr == 11'd0) wrapped = 1'b1;
                prev_rd = rd_word_ptr;
            end
            d = issued * 32 - pos - int'(bit_count);
            check("s_occupancy", (d == 0 || d == 32), 1);

            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) begin
                if (written < TOTAL_BYTES && (written - pos / 8) < 4096) begin
                    mem[wr_ptr] = sbytes[written];
                    wr_ptr = wr_ptr + 13'd1;
                    written++;
                end
            end

            do_align = ($urandom_range(0, 15) == 0);
            len = (pos < 65536) ? 7 : int'($urandom_range(0, 32));
            bits_len = 6'(len);
            bits_valid = ($urandom_range(0, 3) != 0);
            align = do_align;
            settle();
            if (do_align) begin
                check("s_ready_align", bits_ready, 0);
                pos = (pos + 7) & ~7;
            end else begin
                check("s_ready", bits_ready, (int'(bit_count) >= len));
                if (bits_valid && bits_ready) begin
                    check("s_data", bits_data, model_bits(pos, len));
                    pos += len;
                end
            end
            step();
            cyc++;
            if ((cyc % 2048) == 0)
                $display("[TB] stream cycle=%0d bitpos=%0d bytes_written=%0d", cyc, pos, written);
        end
        bits_valid = 1'b0; align = 1'b0; bits_len = 6'd0;
        check("s_completed", (pos >= END_BITS), 1);
        check("s_wrapped", wrapped, 1);

        // Reset while a fetch is in flight
        do_flush();
        push4(32'h5A5A5A5A);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; settle();
        check("r_count0", bit_count, 0);
        check("r_rd0", rd_word_ptr, 0);
        step();
        check("r_stale_ignored", bit_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
